// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch front end.
//
// Issues word reads to a one-cycle-latency instruction memory, captures the
// returned words with their byte PCs in a 2-entry FIFO and offers them to
// decode with a valid/ready handshake. A redirect pulse flushes everything
// buffered or in flight and restarts fetch at the redirect target.
//
// Parameters:
//   ADDR     - instruction memory word-index width
//   DATA     - instruction width
//   RESET_PC - byte address fetched first after reset (ADDR+2 bits)
//
// Ports:
//   clk            - clock, all state changes on its rising edge
//   rst            - synchronous active-high reset
//   imem_addr      - word index to memory (data returns next cycle)
//   imem_data      - memory read data for last cycle's address
//   out_valid      - instruction available to decode
//   out_ready      - decode accepts the instruction
//   out_instr      - instruction word at FIFO head
//   out_pc         - byte address of out_instr
//   redirect_valid - one-cycle redirect pulse (branch/jump/trap)
//   redirect_pc    - redirect target byte address, bits [1:0] ignored
//   perf_fetched   - completed handshakes (FETCH_PERF_EN only)
//   perf_stall     - cycles with out_valid && !out_ready (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
module fetch_controller #(
  parameter int unsigned       ADDR     = 10,
  parameter int unsigned       DATA     = 32,
  parameter logic [ADDR+1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR-1:0]   imem_addr,
  input  logic [DATA-1:0]   imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA-1:0]   out_instr,
  output logic [ADDR+1:0]   out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR+1:0]   redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned PcW = ADDR + 2;
  typedef logic [PcW-1:0] pc_t;

  pc_t             fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  pc_t             inflight_pc_q, inflight_pc_d;

  pc_t             fifo_pc_q    [2];
  logic [DATA-1:0] fifo_instr_q [2];
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      count_q;

  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      pending;
  pc_t             redir_pc_al;

  assign out_valid = (count_q != 2'd0);
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign out_pc    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    pop         = out_valid && out_ready;
    redir_pc_al = redirect_pc & ~pc_t'(3);
    // Occupancy the FIFO will reach once the in-flight word lands, net of
    // this cycle's pop; written as a + b < 2 + pop to avoid underflow.
    pending     = {1'b0, count_q} + {2'b00, inflight_q};
    issue       = !rst && (redirect_valid || (pending < (3'd2 + {2'b00, pop})));
    // A redirect discards the word returning this cycle.
    push        = inflight_q && !redirect_valid;

    if (rst) begin
      imem_addr = RESET_PC[PcW-1:2];
    end else if (redirect_valid) begin
      imem_addr = redirect_pc[PcW-1:2];
    end else begin
      imem_addr = fetch_pc_q[PcW-1:2];
    end

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      fetch_pc_d    = redir_pc_al + pc_t'(4);
      inflight_pc_d = redir_pc_al;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + pc_t'(4);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      if (redirect_valid) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        unique case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      // A handshake coinciding with a redirect still counts as delivered.
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios plus random stimulus,
// checked against a queue-based reference model of the delivered stream.
module tb_fetch_controller;

  localparam int unsigned A      = 10;
  localparam int unsigned PcMask = (1 << (A + 2)) - 1;
  localparam int unsigned RstPc  = 32'h40;

  logic            clk = 1'b0;
  logic            rst;
  logic [A-1:0]    imem_addr;
  logic [31:0]     imem_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [A+1:0]    out_pc;
  logic            redirect_valid;
  logic [A+1:0]    redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
  logic [31:0]     w_perf_fetched;
  logic [31:0]     w_perf_stall;
`endif

  // Small instance for the wrap scenario.
  logic            w_rst;
  logic [3:0]      w_addr;
  logic [31:0]     w_data;
  logic            w_valid;
  logic            w_ready;
  logic [31:0]     w_instr;
  logic [5:0]      w_pc;
  logic            w_redir;
  logic [5:0]      w_rpc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state.
  int unsigned m_q[$];
  bit          m_inf;
  int unsigned m_ipc;
  int unsigned m_fpc;
  int unsigned m_fetched;
  int unsigned m_stall;
  int unsigned w_seen[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int unsigned idx);
    return idx * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  always @(posedge clk) imem_data <= mem_word(32'(imem_addr));
  always @(posedge clk) w_data    <= mem_word(32'(w_addr));

  fetch_controller #(.ADDR(A), .DATA(32), .RESET_PC(12'h040)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  fetch_controller #(.ADDR(4), .DATA(32), .RESET_PC(6'h00)) dut_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .imem_addr      (w_addr),
    .imem_data      (w_data),
    .out_valid      (w_valid),
    .out_ready      (w_ready),
    .out_instr      (w_instr),
    .out_pc         (w_pc),
    .redirect_valid (w_redir),
    .redirect_pc    (w_rpc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (w_perf_fetched),
    .perf_stall     (w_perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Delivered stream rules: sequential PCs from the last restart point, at
  // most two words buffered plus one outstanding, one-cycle memory latency.
  task automatic model_step();
    bit pop;
    int occ;
    if (rst) begin
      m_q.delete();
      m_inf     = 0;
      m_fpc     = RstPc;
      m_fetched = 0;
      m_stall   = 0;
    end else begin
      pop = (m_q.size() > 0) && out_ready;
      if (pop) m_fetched++;
      if ((m_q.size() > 0) && !out_ready) m_stall++;
      if (redirect_valid) begin
        m_q.delete();
        m_inf = 1;
        m_ipc = 32'(redirect_pc) & (PcMask & ~32'h3);
        m_fpc = (m_ipc + 4) & PcMask;
      end else begin
        occ = m_q.size() + int'(m_inf) - int'(pop);
        if (pop) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_ipc);
        if (occ < 2) begin
          m_inf = 1;
          m_ipc = m_fpc;
          m_fpc = (m_fpc + 4) & PcMask;
        end else begin
          m_inf = 0;
        end
      end
    end
  endtask

  // Called right after inputs are driven (just past a falling edge).
  task automatic cycle();
    int unsigned exp_addr;
    #1;
    if (rst) exp_addr = RstPc >> 2;
    else if (redirect_valid) exp_addr = 32'(redirect_pc) >> 2;
    else exp_addr = m_fpc >> 2;
    check("imem_addr", 32'(imem_addr), exp_addr & ((1 << A) - 1));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("out_pc", 32'(out_pc), m_q[0]);
      check("out_instr", out_instr, mem_word(m_q[0] >> 2));
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stall);
`endif
    if (w_valid && w_ready) w_seen.push_back(32'(w_pc));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    w_rst = 1'b1; w_ready = 1'b1; w_redir = 1'b0; w_rpc = '0;
    m_q.delete(); m_inf = 0; m_ipc = 0; m_fpc = RstPc; m_fetched = 0; m_stall = 0;

    // Reset, with a redirect attempted during reset that must be ignored.
    run(2);
    redirect_valid = 1'b1; redirect_pc = 12'h300;
    cycle();
    redirect_valid = 1'b0;
    rst = 1'b0; w_rst = 1'b0;
    run(8);

    // Backpressure for five cycles, then release.
    out_ready = 1'b0;
    run(5);
    out_ready = 1'b1;
    run(6);

    // Redirect while the FIFO is full.
    out_ready = 1'b0;
    run(3);
    redirect_valid = 1'b1; redirect_pc = 12'h200;
    cycle();
    redirect_valid = 1'b0; out_ready = 1'b1;
    run(6);

    // Redirect coinciding with a handshake, unaligned target.
    redirect_valid = 1'b1; redirect_pc = 12'h103;
    cycle();
    redirect_valid = 1'b0;
    run(5);

    // Wrap at the top of memory, on both instances.
    redirect_valid = 1'b1; redirect_pc = 12'hFF8;
    w_redir = 1'b1; w_rpc = 6'h3C;
    cycle();
    check("wrap_flush", 32'(w_valid), 32'd0);
    redirect_valid = 1'b0; w_redir = 1'b0;
    w_seen.delete();
    run(4);
    check("wrap_count", 32'(w_seen.size() >= 3), 32'd1);
    if (w_seen.size() >= 3) begin
      check("wrap_pc0", w_seen[0], 32'h3C);
      check("wrap_pc1", w_seen[1], 32'h00);
      check("wrap_pc2", w_seen[2], 32'h04);
    end

    // Mid-stream reset with a full FIFO, then restart.
    out_ready = 1'b0;
    run(3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h500;
    cycle();
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    run(6);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 12'($urandom_range(0, 4095));
      out_ready      = ($urandom_range(0, 9) < 7);
      cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
